// File: rtl/rand_delay_pkg.sv
// Shared types and constants for the reaction-timer random-delay generator.
package rand_delay_pkg;

    // Width of every millisecond quantity; holds values up to 9999.
    localparam int MS_W = 14;

    // Feedback taps of the 16-bit Fibonacci LFSR: bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } delay_state_t;

    // One shift of the LFSR: feedback is the XOR of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// in the cycle the count sits at TICK_DIV-1, wrapping on that same edge.
module ms_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Prescaler count: clear wins over enable, wrap after the last value.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and simulation matches the hardware.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rand_delay_gen.sv
// Random-delay generator: on request, captures an LFSR nibble, turns it into
// BASE_MS + nibble*STEP_MS milliseconds, counts that down on a 1 ms tick and
// returns a one-cycle done pulse.
module rand_delay_gen
    import rand_delay_pkg::*;
#(
    parameter int          TICK_DIV = 100_000,
    parameter int          BASE_MS  = 1000,
    parameter int          STEP_MS  = 250,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [MS_W-1:0] delay_ms,
    output logic [MS_W-1:0] remaining_ms
);

    localparam logic [MS_W-1:0] BASE_W = MS_W'(BASE_MS);
    localparam logic [MS_W-1:0] STEP_W = MS_W'(STEP_MS);

    delay_state_t    state;
    delay_state_t    state_next;
    logic [15:0]     lfsr;
    logic [MS_W-1:0] load_value;
    logic            tick;

    // Delay derived from the low nibble; parameter limits keep it under 10000.
    assign load_value = BASE_W + MS_W'(lfsr[3:0]) * STEP_W;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == LOAD),
        .en   (state == COUNT),
        .tick (tick)
    );

    // Free-running pseudo-random source, advancing every non-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: abort beats start, start is ignored unless idle.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = abort ? IDLE : COUNT;
            end
            COUNT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tick && (remaining_ms == MS_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Delay capture on LOAD, countdown on each tick; an abort freezes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            delay_ms     <= '0;
            remaining_ms <= '0;
        end else if (state == LOAD) begin
            delay_ms     <= load_value;
            remaining_ms <= load_value;
        end else if ((state == COUNT) && tick && !abort) begin
            remaining_ms <= remaining_ms - 1'b1;
        end
    end

    assign busy = (state == LOAD) || (state == COUNT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rand_delay_gen.sv
// Bench for rand_delay_gen: a cycle table on a fixed-delay instance, random
// requests on a default-parameter instance against an LFSR/arithmetic model,
// an LFSR period watch, and a mid-count reset.
module tb_rand_delay_gen;

    localparam int          TD   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_start, f_abort, f_busy, f_done;
    logic [13:0] f_delay, f_rem;
    logic        r_start, r_abort, r_busy, r_done;
    logic [13:0] r_delay, r_rem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rand_delay_gen #(
        .TICK_DIV (TD),
        .BASE_MS  (3),
        .STEP_MS  (0),
        .SEED     (SEED)
    ) dut_fix (
        .clk          (clk),
        .rst          (rst),
        .start        (f_start),
        .abort        (f_abort),
        .busy         (f_busy),
        .done         (f_done),
        .delay_ms     (f_delay),
        .remaining_ms (f_rem)
    );

    rand_delay_gen #(
        .TICK_DIV (TD)
    ) dut_rnd (
        .clk          (clk),
        .rst          (rst),
        .start        (r_start),
        .abort        (r_abort),
        .busy         (r_busy),
        .done         (r_done),
        .delay_ms     (r_delay),
        .remaining_ms (r_rem)
    );

    // Reference LFSR straight from the update rule.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic        busy;
        logic        done;
        logic [13:0] rem;
        logic [13:0] dly;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic a, input logic b, input logic d,
                       input int rem, input int dly, input int n);
        vec_t v;
        v.start = s; v.abort = a; v.busy = b; v.done = d;
        v.rem = 14'(rem); v.dly = 14'(dly);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Fixed delay 3 ms, 4 cycles per tick: start in cycle 3 gives LOAD in 4,
    // COUNT from 5, ticks after cycles 8, 12, 16, done in cycle 17.
    task automatic build_table();
        add(0, 0, 0, 0, 0, 0, 1); // c0  idle after reset
        add(1, 1, 0, 0, 0, 0, 1); // c1  start+abort together
        add(0, 0, 0, 0, 0, 0, 1); // c2  still idle
        add(1, 0, 0, 0, 0, 0, 1); // c3  request
        add(0, 0, 1, 0, 0, 0, 1); // c4  LOAD
        add(0, 0, 1, 0, 3, 3, 1); // c5  COUNT begins
        add(1, 0, 1, 0, 3, 3, 1); // c6  start while busy
        add(0, 0, 1, 0, 3, 3, 2); // c7-c8
        add(0, 0, 1, 0, 2, 3, 4); // c9-c12
        add(0, 0, 1, 0, 1, 3, 4); // c13-c16
        add(1, 0, 0, 1, 0, 3, 1); // c17 DONE, start ignored
        add(1, 0, 0, 0, 0, 3, 1); // c18 idle, start accepted
        add(0, 0, 1, 0, 0, 3, 1); // c19 LOAD
        add(0, 0, 1, 0, 3, 3, 4); // c20-c23 COUNT
        add(0, 0, 1, 0, 2, 3, 1); // c24
        add(0, 1, 1, 0, 2, 3, 1); // c25 abort, 5 cycles into COUNT
        add(0, 0, 0, 0, 2, 3, 1); // c26 idle, count frozen at 2
    endtask

    task automatic run_table();
        int seen_done;
        for (int i = 0; i < vecs.size(); i++) begin
            step();
            check($sformatf("tbl%0d_busy", i), f_busy, vecs[i].busy);
            check($sformatf("tbl%0d_done", i), f_done, vecs[i].done);
            check($sformatf("tbl%0d_rem", i), f_rem, vecs[i].rem);
            check($sformatf("tbl%0d_dly", i), f_delay, vecs[i].dly);
            f_start = vecs[i].start;
            f_abort = vecs[i].abort;
        end
        f_start = 1'b0;
        f_abort = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (f_done || f_busy) seen_done++;
        end
        check("abort_no_done_50", seen_done, 0);
        check("abort_rem_hold", f_rem, 2);
    endtask

    task automatic run_random();
        bit [15:0] seen;
        int        distinct;
        int        expd;
        int        k;
        seen = '0;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 7) == 0) begin
                r_start = 1'b1; r_abort = 1'b1;
                step();
                r_start = 1'b0; r_abort = 1'b0;
                check("rnd_collide_busy", r_busy, 0);
                step();
                check("rnd_collide_idle", r_busy, 0);
            end
            r_start = 1'b1;
            step();
            r_start = 1'b0;
            check("rnd_load_busy", r_busy, 1);
            expd = 1000 + int'(m_lfsr[3:0]) * 250;
            step();
            check("rnd_delay", r_delay, expd);
            check("rnd_rem_init", r_rem, expd);
            check("rnd_in_range", (r_delay >= 1000) && (r_delay <= 4750) &&
                  ((int'(r_delay) - 1000) % 250 == 0), 1);
            if ((r_delay >= 1000) && (r_delay <= 4750))
                seen[(int'(r_delay) - 1000) / 250] = 1'b1;
            k = $urandom_range(0, 5);
            repeat (k) step();
            r_abort = 1'b1;
            step();
            r_abort = 1'b0;
            check("rnd_abort_busy", r_busy, 0);
            check("rnd_abort_done", r_done, 0);
            check("rnd_abort_rem", r_rem, expd - k / TD);
        end
        distinct = 0;
        for (int i = 0; i < 16; i++) distinct += int'(seen[i]);
        check("rnd_distinct_ge8", distinct >= 8, 1);
    endtask

    task automatic watch_lfsr();
        int first_ret = 0;
        int zeros = 0;
        for (int c = 1; c <= 65535; c++) begin
            step();
            if (dut_rnd.lfsr == 16'h0) zeros++;
            if ((dut_rnd.lfsr == SEED) && (first_ret == 0)) first_ret = c;
        end
        check("lfsr_period", first_ret, 65535);
        check("lfsr_never_zero", zeros, 0);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1;
        f_start = 1'b0; f_abort = 1'b0;
        r_start = 1'b0; r_abort = 1'b0;
        build_table();
        repeat (2) step();
        check("rst_busy", f_busy, 0);
        check("rst_done", f_done, 0);
        check("rst_delay", r_delay, 0);
        check("rst_rem", r_rem, 0);
        rst = 1'b0;

        fork
            watch_lfsr();
            begin
                run_table();
                run_random();
            end
        join

        // Reset in the middle of a countdown.
        f_start = 1'b1;
        step();
        f_start = 1'b0;
        repeat (4) step();
        check("mid_busy", f_busy, 1);
        rst = 1'b1;
        step();
        check("mrst_busy", f_busy, 0);
        check("mrst_done", f_done, 0);
        check("mrst_delay", f_delay, 0);
        check("mrst_rem", f_rem, 0);
        check("mrst_lfsr", dut_fix.lfsr, SEED);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (f_done || f_busy) seen_done++;
        end
        check("mrst_no_done", seen_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
